// File: rtl/exc_vector_seq.sv
// rtl/exc_vector_seq.sv - exception vector sequencer for the multicycle MIPS datapath
//
// Purpose: on an enabled exception flag, records EPC (pc_in - 4), steers the
// memory address mux to the fixed vector byte (253/254/255), waits MEM_LAT
// cycles for the read, then loads the zero-extended handler byte into PC.
// Outside an exception the control unit's selector and write enable pass through.
//
// Ports:
//   clk, reset (async, active-low)
//   exc_enable, opcode_invalid, overflow, div_zero : exception qualifiers/flags
//   pc_in          : PC already incremented by 4
//   ctrl_mem_sel   : control unit address-mux selector
//   ctrl_mem_wr    : control unit memory write enable
//   mem_data_in    : memory read data, handler address in [7:0]
//   mem_sel_out    : selector to the address mux
//   mem_wr_out     : gated memory write enable
//   epc_out/epc_wr : EPC value and one-cycle load strobe
//   pc_out/pc_wr   : handler address and one-cycle PC load strobe
//   exc_cause      : latched cause (0 opcode, 1 overflow, 2 div-zero)
//   busy           : high while sequencing

module exc_vector_seq #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_enable,
  input  logic        opcode_invalid,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_in,
  input  logic [2:0]  ctrl_mem_sel,
  input  logic        ctrl_mem_wr,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  mem_sel_out,
  output logic        mem_wr_out,
  output logic [31:0] epc_out,
  output logic        epc_wr,
  output logic [31:0] pc_out,
  output logic        pc_wr,
  output logic [1:0]  exc_cause,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Counter preload: the read data is sampled on the edge where the counter is 0,
  // which lands exactly MEM_LAT edges after the trigger edge.
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       trigger;
  logic [1:0] cause_next;
  logic       unused_mem_hi;

  assign trigger = exc_enable & (opcode_invalid | overflow | div_zero);

  // Fixed priority: opcode_invalid > overflow > div_zero.
  always_comb begin
    cause_next = 2'd2;
    if (opcode_invalid) begin
      cause_next = 2'd0;
    end else if (overflow) begin
      cause_next = 2'd1;
    end
  end

  // Only the low byte of the read data carries the handler address.
  assign unused_mem_hi = ^mem_data_in[31:8];

  assign busy = (state != IDLE);

  // The selector must follow the control unit with no added latency in IDLE,
  // so the mux path stays combinational; while busy it is pinned to the vector.
  always_comb begin
    mem_sel_out = ctrl_mem_sel;
    mem_wr_out  = ctrl_mem_wr;
    if (state != IDLE) begin
      mem_sel_out = 3'b100 + {1'b0, exc_cause};
      mem_wr_out  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      epc_out   <= 32'd0;
      epc_wr    <= 1'b0;
      pc_out    <= 32'd0;
      pc_wr     <= 1'b0;
      exc_cause <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            exc_cause <= cause_next;
            epc_out   <= pc_in - 32'd4;
            epc_wr    <= 1'b1;
            cnt       <= LAT_M1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          // EPC strobe covers only the first FETCH cycle; flags are ignored here.
          epc_wr <= 1'b0;
          if (cnt == 3'd0) begin
            pc_out <= {24'b0, mem_data_in[7:0]};
            pc_wr  <= 1'b1;
            state  <= LOAD;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        LOAD: begin
          pc_wr <= 1'b0;
          state <= IDLE;
        end
        default: begin
          epc_wr <= 1'b0;
          pc_wr  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_vector_seq.sv
// tb/tb_exc_vector_seq.sv - self-checking bench for exc_vector_seq

module tb_exc_vector_seq;

  typedef struct {
    logic        opc;
    logic        ovf;
    logic        dz;
    logic [31:0] pc;
    logic [31:0] mem;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic [31:0] pco;
    logic [2:0]  sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_enable = 1'b0;
  logic        opcode_invalid = 1'b0;
  logic        overflow = 1'b0;
  logic        div_zero = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic [2:0]  ctrl_mem_sel = 3'b010;
  logic        ctrl_mem_wr = 1'b1;
  logic [31:0] mem_data_in = 32'd0;

  logic [2:0]  mem_sel_out;
  logic        mem_wr_out;
  logic [31:0] epc_out;
  logic        epc_wr;
  logic [31:0] pc_out;
  logic        pc_wr;
  logic [1:0]  exc_cause;
  logic        busy;

  logic [2:0]  mem_sel_out1;
  logic        mem_wr_out1;
  logic [31:0] epc_out1;
  logic        epc_wr1;
  logic [31:0] pc_out1;
  logic        pc_wr1;
  logic [1:0]  exc_cause1;
  logic        busy1;

  int checks = 0;
  int failures = 0;
  vec_t sb[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  exc_vector_seq #(.MEM_LAT(2)) dut (
    .clk(clk), .reset(reset), .exc_enable(exc_enable),
    .opcode_invalid(opcode_invalid), .overflow(overflow), .div_zero(div_zero),
    .pc_in(pc_in), .ctrl_mem_sel(ctrl_mem_sel), .ctrl_mem_wr(ctrl_mem_wr),
    .mem_data_in(mem_data_in), .mem_sel_out(mem_sel_out), .mem_wr_out(mem_wr_out),
    .epc_out(epc_out), .epc_wr(epc_wr), .pc_out(pc_out), .pc_wr(pc_wr),
    .exc_cause(exc_cause), .busy(busy)
  );

  exc_vector_seq #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .exc_enable(exc_enable),
    .opcode_invalid(opcode_invalid), .overflow(overflow), .div_zero(div_zero),
    .pc_in(pc_in), .ctrl_mem_sel(ctrl_mem_sel), .ctrl_mem_wr(ctrl_mem_wr),
    .mem_data_in(mem_data_in), .mem_sel_out(mem_sel_out1), .mem_wr_out(mem_wr_out1),
    .epc_out(epc_out1), .epc_wr(epc_wr1), .pc_out(pc_out1), .pc_wr(pc_wr1),
    .exc_cause(exc_cause1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every PC load strobe of the MEM_LAT=2 instance must match the
  // oldest outstanding expected exception.
  always @(negedge clk) begin
    if (pc_wr === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pc_wr", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("sb_pc_out", pc_out, e.pco);
        chk("sb_cause", {30'd0, exc_cause}, {30'd0, e.cause});
        chk("sb_epc_out", epc_out, e.epc);
        chk("sb_sel_load", {29'd0, mem_sel_out}, {29'd0, e.sel});
      end
    end
  end

  // Raises the vector's flags for one edge and follows the exception until idle.
  task automatic run_vec(input vec_t v);
    int busy_cyc;
    int epc_pulses;
    @(posedge clk); #1;
    exc_enable = 1'b1;
    opcode_invalid = v.opc;
    overflow = v.ovf;
    div_zero = v.dz;
    pc_in = v.pc;
    mem_data_in = v.mem;
    ctrl_mem_sel = 3'b001;
    ctrl_mem_wr = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    exc_enable = 1'b0;
    opcode_invalid = 1'b0;
    overflow = 1'b0;
    div_zero = 1'b0;
    busy_cyc = 0;
    epc_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      busy_cyc++;
      chk("vec_sel", {29'd0, mem_sel_out}, {29'd0, v.sel});
      chk("vec_wr_masked", {31'd0, mem_wr_out}, 32'd0);
      if (i == 0) begin
        chk("vec_epc_wr_first", {31'd0, epc_wr}, 32'd1);
        chk("vec_epc_out", epc_out, v.epc);
      end
      if (epc_wr === 1'b1) epc_pulses++;
    end
    chk("vec_busy_cycles", busy_cyc, 32'd3);
    chk("vec_epc_pulses", epc_pulses, 32'd1);
  endtask

  initial begin
    int n;
    int n1;
    int pw1;
    vec_t h;

    vecs[0] = '{opc:1'b0, ovf:1'b1, dz:1'b0, pc:32'h0000_0104, mem:32'h0000_008C,
                cause:2'd1, epc:32'h0000_0100, pco:32'h0000_008C, sel:3'b101};
    vecs[1] = '{opc:1'b1, ovf:1'b0, dz:1'b1, pc:32'h0000_2000, mem:32'h1234_56A7,
                cause:2'd0, epc:32'h0000_1FFC, pco:32'h0000_00A7, sel:3'b100};
    vecs[2] = '{opc:1'b0, ovf:1'b0, dz:1'b1, pc:32'h8000_0000, mem:32'hFFFF_FF01,
                cause:2'd2, epc:32'h7FFF_FFFC, pco:32'h0000_0001, sel:3'b110};
    vecs[3] = '{opc:1'b1, ovf:1'b1, dz:1'b1, pc:32'h0000_0010, mem:32'h0000_00FF,
                cause:2'd0, epc:32'h0000_000C, pco:32'h0000_00FF, sel:3'b100};
    vecs[4] = '{opc:1'b0, ovf:1'b1, dz:1'b1, pc:32'hDEAD_BEEF, mem:32'h0000_0042,
                cause:2'd1, epc:32'hDEAD_BEEB, pco:32'h0000_0042, sel:3'b101};

    // Reset state while reset is held low.
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_epc_out", epc_out, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_cause", {30'd0, exc_cause}, 32'd0);
    chk("rst_sel_track", {29'd0, mem_sel_out}, 32'd2);
    chk("rst_wr_track", {31'd0, mem_wr_out}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // Passthrough: flags ignored without exc_enable.
    exc_enable = 1'b0;
    overflow = 1'b1;
    ctrl_mem_sel = 3'b011;
    ctrl_mem_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pass_busy", {31'd0, busy}, 32'd0);
      chk("pass_sel", {29'd0, mem_sel_out}, 32'd3);
      chk("pass_wr", {31'd0, mem_wr_out}, 32'd1);
      chk("pass_epc_wr", {31'd0, epc_wr}, 32'd0);
    end
    overflow = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Flags held through FETCH/LOAD: no re-latch; next trigger right after LOAD.
    @(posedge clk); #1;
    exc_enable = 1'b1;
    div_zero = 1'b1;
    pc_in = 32'h0000_0040;
    mem_data_in = 32'h0000_0033;
    h = '{opc:1'b0, ovf:1'b0, dz:1'b1, pc:32'h40, mem:32'h33,
          cause:2'd2, epc:32'h3C, pco:32'h33, sel:3'b110};
    sb.push_back(h);
    @(posedge clk); #1;
    opcode_invalid = 1'b1;
    overflow = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      chk("hold_cause", {30'd0, exc_cause}, 32'd2);
    end
    chk("hold_busy_cycles", n, 32'd3);
    opcode_invalid = 1'b0;
    div_zero = 1'b0;
    pc_in = 32'h0000_0084;
    mem_data_in = 32'h0000_005A;
    h = '{opc:1'b0, ovf:1'b1, dz:1'b0, pc:32'h84, mem:32'h5A,
          cause:2'd1, epc:32'h80, pco:32'h5A, sel:3'b101};
    sb.push_back(h);
    @(posedge clk); #1;
    exc_enable = 1'b0;
    overflow = 1'b0;
    chk("retrigger_busy", {31'd0, busy}, 32'd1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    chk("retrigger_busy_cycles", n, 32'd3);

    // pc_in = 0 wraps; MEM_LAT=1 instance is busy two cycles.
    @(posedge clk); #1;
    exc_enable = 1'b1;
    overflow = 1'b1;
    pc_in = 32'h0000_0000;
    mem_data_in = 32'hABCD_00C4;
    h = '{opc:1'b0, ovf:1'b1, dz:1'b0, pc:32'h0, mem:32'hABCD_00C4,
          cause:2'd1, epc:32'hFFFF_FFFC, pco:32'hC4, sel:3'b101};
    sb.push_back(h);
    @(posedge clk); #1;
    exc_enable = 1'b0;
    overflow = 1'b0;
    chk("lat1_epc_out", epc_out1, 32'hFFFF_FFFC);
    n1 = 0;
    pw1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy1 === 1'b1) n1++;
      if (pc_wr1 === 1'b1) begin
        pw1++;
        chk("lat1_pc_out", pc_out1, 32'h0000_00C4);
      end
      if (busy !== 1'b1 && busy1 !== 1'b1) break;
    end
    chk("lat1_busy_cycles", n1, 32'd2);
    chk("lat1_pc_wr_pulses", pw1, 32'd1);

    // Reset mid-FETCH aborts immediately.
    @(posedge clk); #1;
    exc_enable = 1'b1;
    overflow = 1'b1;
    pc_in = 32'h0000_1004;
    @(posedge clk); #1;
    exc_enable = 1'b0;
    overflow = 1'b0;
    chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    ctrl_mem_sel = 3'b010;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pc_wr", {31'd0, pc_wr}, 32'd0);
    chk("midrst_epc_out", epc_out, 32'd0);
    chk("midrst_sel", {29'd0, mem_sel_out}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_pc_wr", {31'd0, pc_wr}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
